adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arb_pkg.sv | 9 +
 rtl/adder_arbiter_rr_pick.sv | 26 ++
 rtl/adder_arbiter.sv | 79 +++++++
 tb/tb_adder_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared types, defaults and ID-width helper for the adder arbiter
package adder_arb_pkg;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_NREQ = 4;
   typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector scanning upward from ptr with wrap
module rr_pick import adder_arb_pkg::*; #(
   parameter int NREQ = DEF_NREQ,
   parameter int IW = id_w(NREQ)
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx
);
   logic [IW-1:0] k;
   // Walk from the farthest offset to the nearest so the nearest valid wins
   always_comb begin
      grant = '0;
      idx = '0;
      k = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         k = IW'((int'(ptr) + i) % NREQ);
         if (valid[k]) begin
            grant = '0;
            grant[k] = 1'b1;
            idx = k;
         end
      end
   end
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbitration of NREQ requesters onto one external adder
module adder_arbiter import adder_arb_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREQ = DEF_NREQ,
   parameter int SETTLE_CYC = 2,
   localparam int IW = id_w(NREQ)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ-1:0][WIDTH-1:0] req_a,
   input  logic [NREQ-1:0][WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]            req_cin,
   output logic [WIDTH-1:0]           add_a,
   output logic [WIDTH-1:0]           add_b,
   output logic                       add_cin,
   input  logic [WIDTH-1:0]           add_out,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [WIDTH-1:0]           rsp_sum,
   output logic [IW-1:0]              rsp_id,
   output logic                       busy
);
   state_t state, state_nxt;
   logic [IW-1:0] ptr, pick_idx;
   logic [NREQ-1:0] grant;
   logic [3:0] cnt;
   logic accept;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .valid(req_valid),
      .ptr(ptr),
      .grant(grant),
      .idx(pick_idx)
   );

   assign accept = (state == IDLE) && |req_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else state <= state_nxt;
   end

   // The handshake cycle always returns to IDLE, so no accept can overlap it
   always_comb begin
      state_nxt = (state == IDLE) ? (accept ? SETTLE : IDLE) :
                  (state == SETTLE) ? ((cnt == 4'd0) ? RESP : SETTLE) :
                  (rsp_ready ? IDLE : RESP);
   end

   always_comb begin
      req_ready = (state == IDLE) ? grant : '0;
      busy = state != IDLE;
      rsp_valid = state == RESP;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
         cnt <= '0;
         add_a <= '0;
         add_b <= '0;
         add_cin <= 1'b0;
         rsp_sum <= '0;
         rsp_id <= '0;
      end else if (accept) begin
         add_a <= req_a[pick_idx];
         add_b <= req_b[pick_idx];
         add_cin <= req_cin[pick_idx];
         rsp_id <= pick_idx;
         cnt <= 4'(SETTLE_CYC - 1);
         ptr <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
      end else if (state == SETTLE) begin
         if (cnt == 4'd0) rsp_sum <= add_out;
         else cnt <= cnt - 4'd1;
      end
   end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed self-checking bench for adder_arbiter with an external adder
module tb_adder_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [3:0] req_valid = '0, req_ready, req_cin = '0;
   logic [3:0][31:0] req_a = '0, req_b = '0;
   logic [31:0] add_a, add_b, add_out, rsp_sum;
   logic add_cin, rsp_valid, rsp_ready = 1'b1, busy;
   logic [1:0] rsp_id;
   logic [3:0] v1 = '0, rr1, cin1 = '0;
   logic [3:0][31:0] a1 = '0, b1 = '0;
   logic [31:0] add_a1, add_b1, add_out1, sum1;
   logic add_cin1, rv1, busy1;
   logic [1:0] id1;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   assign add_out = add_a + add_b + {31'd0, add_cin};
   assign add_out1 = add_a1 + add_b1 + {31'd0, add_cin1};

   adder_arbiter #(.WIDTH(32), .NREQ(4), .SETTLE_CYC(2)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .add_a(add_a), .add_b(add_b),
      .add_cin(add_cin), .add_out(add_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_sum(rsp_sum), .rsp_id(rsp_id), .busy(busy)
   );

   adder_arbiter #(.WIDTH(32), .NREQ(4), .SETTLE_CYC(1)) u_dut1 (
      .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rr1),
      .req_a(a1), .req_b(b1), .req_cin(cin1), .add_a(add_a1), .add_b(add_b1),
      .add_cin(add_cin1), .add_out(add_out1), .rsp_valid(rv1), .rsp_ready(1'b1),
      .rsp_sum(sum1), .rsp_id(id1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_add_a", add_a, 0);
      chk("rst_rsp_sum", rsp_sum, 0);
      reset = 1'b0;
      #1;
      chk("rst_ready", req_ready, 0);
      // single requester 2: 5 + 7 + 1
      req_a[2] = 32'h5; req_b[2] = 32'h7; req_cin[2] = 1'b1; req_valid = 4'b0100;
      #1;
      chk("r2_grant", req_ready, 4'b0100);
      step();
      req_valid = '0;
      #1;
      chk("r2_busy", busy, 1);
      chk("r2_ready0", req_ready, 0);
      chk("r2_add_a", add_a, 32'h5);
      step();
      chk("r2_lat_t2", rsp_valid, 0);
      step();
      chk("r2_lat_t3", rsp_valid, 1);
      chk("r2_sum", rsp_sum, 32'hD);
      chk("r2_id", rsp_id, 2);
      step();
      chk("r2_idle", busy, 0);
      // all four valid after reset: order 0,1,2,3,0 spaced 4 cycles
      reset = 1'b1;
      #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_a[i] = 32'h100 * i + 1; req_b[i] = i; req_cin[i] = i[0];
      end
      req_valid = 4'b1111;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk("rr_grant", req_ready, 4'b0001 << (k % 4));
         step();
         chk("rr_hold", req_ready, 0);
         step();
         step();
         chk("rr_valid", rsp_valid, 1);
         chk("rr_id", rsp_id, k % 4);
         chk("rr_sum", rsp_sum, 32'h100 * (k % 4) + 1 + (k % 4) + (k % 2));
         step();
      end
      req_valid = '0;
      // wrap: ptr=1, only requester 0 valid, FFFFFFFF + 0 + 1
      req_a[0] = 32'hFFFFFFFF; req_b[0] = 32'h0; req_cin[0] = 1'b1; req_valid = 4'b0001;
      #1;
      chk("ov_grant", req_ready, 4'b0001);
      step();
      req_valid = '0;
      step();
      step();
      chk("ov_valid", rsp_valid, 1);
      chk("ov_sum", rsp_sum, 32'h0);
      step();
      // backpressure: requester 3 served, requester 1 waits through 10 stalled cycles
      req_a[3] = 32'h10; req_b[3] = 32'h20; req_cin[3] = 1'b0; req_valid = 4'b1000;
      rsp_ready = 1'b0;
      #1;
      chk("bp_grant3", req_ready, 4'b1000);
      step();
      req_a[1] = 32'h1; req_b[1] = 32'h2; req_cin[1] = 1'b0; req_valid = 4'b0010;
      step();
      step();
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", rsp_valid, 1);
         chk("bp_sum", rsp_sum, 32'h30);
         chk("bp_id", rsp_id, 3);
         chk("bp_ready0", req_ready, 0);
         chk("bp_add_a", add_a, 32'h10);
         step();
      end
      rsp_ready = 1'b1;
      #1;
      chk("hs_valid", rsp_valid, 1);
      chk("hs_no_accept", req_ready, 0);
      step();
      chk("bp_grant1", req_ready, 4'b0010);
      chk("bp_idle", busy, 0);
      step();
      req_valid = '0;
      step();
      step();
      chk("bp_sum1", rsp_sum, 32'h3);
      chk("bp_id1", rsp_id, 1);
      step();
      // reset in first SETTLE cycle aborts the operation
      req_a[2] = 32'h7; req_b[2] = 32'h8; req_valid = 4'b0100;
      #1;
      chk("ab_grant", req_ready, 4'b0100);
      step();
      req_valid = '0;
      #1;
      reset = 1'b1;
      #1;
      chk("ab_busy", busy, 0);
      chk("ab_add_a", add_a, 0);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("ab_no_rsp", rsp_valid, 0);
      end
      req_valid = 4'b1001;
      #1;
      chk("ab_grant0", req_ready, 4'b0001);
      step();
      req_valid = '0;
      step();
      step();
      chk("ab_rsp_id", rsp_id, 0);
      step();
      // SETTLE_CYC=1 build: response in T+2
      a1[1] = 32'h1234; b1[1] = 32'h1111; v1 = 4'b0010;
      #1;
      chk("s1_grant", rr1, 4'b0010);
      step();
      v1 = '0;
      #1;
      chk("s1_t1", rv1, 0);
      step();
      chk("s1_t2", rv1, 1);
      chk("s1_sum", sum1, 32'h2345);
      chk("s1_id", id1, 1);
      step();
      chk("s1_idle", busy1, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
